// File: rtl/uart_cmd_decoder.sv
// Framed register-write command decoder: buffers a SYNC/LEN/ADDR/DATA/CHK frame from the UART
// receiver, verifies the checksum and replays it as address/data writes. Optional macro: CMD_ACK_EN.
module uart_cmd_decoder #(
    parameter logic [7:0]  SYNC    = 8'hA5,
    parameter int unsigned MAXLEN  = 16,
    parameter int unsigned TIMEOUT = 480_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       received,
    input  logic [7:0] rx_byte,
    input  logic       recv_error,
    output logic       wr_valid,
    input  logic       wr_ready,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [2:0] err_code,
    output logic       overrun,
    output logic       transmit,
    output logic [7:0] tx_byte,
    input  logic       tx_free
);
    localparam int unsigned IW = $clog2(MAXLEN + 1);
    localparam int unsigned AW = $clog2(MAXLEN);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    localparam logic [2:0] ERR_BADLEN  = 3'd1;
    localparam logic [2:0] ERR_CHKSUM  = 3'd2;
    localparam logic [2:0] ERR_LINE    = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT = 3'd4;

    typedef enum logic [2:0] {
        IDLE, GET_LEN, GET_ADDR, GET_DATA, GET_CHK, DRAIN
    } state_t;

    state_t        state, state_next;
    logic [IW-1:0] len, idx;
    logic [7:0]    addr, sum;
    logic [TW-1:0] tcnt;
    logic [7:0]    mem [MAXLEN];

    logic          byte_ok, in_frame, timeout_hit, reject, done, accept;
    logic [2:0]    rej_code;
    logic [7:0]    chk;
    logic [IW-1:0] len_m1, idx_inc;

    assign byte_ok     = received && !recv_error;
    assign in_frame    = (state == GET_LEN) || (state == GET_ADDR) ||
                         (state == GET_DATA) || (state == GET_CHK);
    assign timeout_hit = in_frame && !received && (tcnt == TW'(TIMEOUT - 1));
    assign chk         = sum + rx_byte;
    assign len_m1      = len - IW'(1);
    assign idx_inc     = idx + IW'(1);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next state and per-cycle strobes; line errors beat bytes, bytes beat the timeout.
    always_comb begin
        state_next = state;
        reject     = 1'b0;
        rej_code   = 3'd0;
        done       = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: if (byte_ok && rx_byte == SYNC) state_next = GET_LEN;
            GET_LEN, GET_ADDR, GET_DATA, GET_CHK: begin
                if (recv_error) begin
                    reject   = 1'b1;
                    rej_code = ERR_LINE;
                end else if (received) begin
                    case (state)
                        GET_LEN:
                            if (rx_byte == 8'd0 || 9'(rx_byte) > 9'(MAXLEN)) begin
                                reject   = 1'b1;
                                rej_code = ERR_BADLEN;
                            end else begin
                                state_next = GET_ADDR;
                            end
                        GET_ADDR: state_next = GET_DATA;
                        GET_DATA: if (idx == len_m1) state_next = GET_CHK;
                        default:
                            if (chk == 8'd0) begin
                                state_next = DRAIN;
                            end else begin
                                reject   = 1'b1;
                                rej_code = ERR_CHKSUM;
                            end
                    endcase
                end else if (timeout_hit) begin
                    reject   = 1'b1;
                    rej_code = ERR_TIMEOUT;
                end
                if (reject) state_next = IDLE;
            end
            DRAIN: begin
                if (wr_valid && wr_ready) begin
                    accept = 1'b1;
                    if (idx == len_m1) begin
                        done       = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Payload buffer; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (state == GET_DATA && byte_ok) mem[idx[AW-1:0]] <= rx_byte;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len       <= '0;
            idx       <= '0;
            addr      <= 8'd0;
            sum       <= 8'd0;
            tcnt      <= '0;
            wr_valid  <= 1'b0;
            wr_addr   <= 8'd0;
            wr_data   <= 8'd0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            err_code  <= 3'd0;
            overrun   <= 1'b0;
        end else begin
            frame_ok  <= done;
            frame_err <= reject;
            if (reject) err_code <= rej_code;

            if (state == IDLE || state == DRAIN || received) tcnt <= '0;
            else                                             tcnt <= tcnt + TW'(1);

            case (state)
                GET_LEN:  if (byte_ok) len <= IW'(rx_byte);
                GET_ADDR: if (byte_ok) begin
                    addr <= rx_byte;
                    sum  <= rx_byte;
                    idx  <= '0;
                end
                GET_DATA: if (byte_ok) begin
                    sum <= chk;
                    idx <= idx_inc;
                end
                GET_CHK: if (state_next == DRAIN) begin
                    idx      <= '0;
                    wr_valid <= 1'b1;
                    wr_addr  <= addr;
                    wr_data  <= mem[0];
                end
                DRAIN: begin
                    if (received) overrun <= 1'b1;
                    if (accept) begin
                        if (done) begin
                            wr_valid <= 1'b0;
                        end else begin
                            idx     <= idx_inc;
                            wr_addr <= addr + 8'(idx_inc);
                            wr_data <= mem[idx_inc[AW-1:0]];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CMD_ACK_EN
    logic       pending;
    logic [7:0] pend_byte;

    // One-entry ACK/NAK slot; a newer response overwrites an unsent one.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending   <= 1'b0;
            pend_byte <= 8'd0;
            transmit  <= 1'b0;
            tx_byte   <= 8'd0;
        end else begin
            transmit <= 1'b0;
            if (pending && tx_free && !transmit) begin
                transmit <= 1'b1;
                tx_byte  <= pend_byte;
                pending  <= 1'b0;
            end
            if (done) begin
                pending   <= 1'b1;
                pend_byte <= 8'h06;
            end else if (reject) begin
                pending   <= 1'b1;
                pend_byte <= 8'h15;
            end
        end
    end
`else
    logic unused_tx_free;
    assign unused_tx_free = tx_free;
    assign transmit       = 1'b0;
    assign tx_byte        = 8'd0;
`endif

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Scoreboard bench for uart_cmd_decoder: stimulus pushes expected writes/results, a monitor pops and compares.
module tb_uart_cmd_decoder;
    localparam int unsigned TMO = 40;

    logic       clk = 1'b0;
    logic       rst, received, recv_error, wr_ready, tx_free;
    logic [7:0] rx_byte;
    logic       wr_valid, frame_ok, frame_err, overrun, transmit;
    logic [7:0] wr_addr, wr_data, tx_byte;
    logic [2:0] err_code;

    uart_cmd_decoder #(.SYNC(8'hA5), .MAXLEN(16), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .received(received), .rx_byte(rx_byte),
        .recv_error(recv_error), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .frame_ok(frame_ok),
        .frame_err(frame_err), .err_code(err_code), .overrun(overrun),
        .transmit(transmit), .tx_byte(tx_byte), .tx_free(tx_free)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         kind;   // 0 write, 1 frame_ok, 2 frame_err
        logic [7:0] a;
        logic [7:0] d;      // data, or error code
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] ack_q[$];
    int         checks   = 0;
    int         failures = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic pop_check(input int kind, input logic [7:0] a, input logic [7:0] d);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event actual_kind=%0d required=none at %0t", kind, $time);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", kind, e.kind);
            if (kind == 0) begin
                check("wr_addr", int'(a), int'(e.a));
                check("wr_data", int'(d), int'(e.d));
            end else if (kind == 2) begin
                check("err_code", int'(d), int'(e.d));
            end
        end
    endtask

    // Monitor: every accepted write, frame result and transmit is compared against the queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (wr_valid && wr_ready) pop_check(0, wr_addr, wr_data);
            if (frame_ok)  pop_check(1, 8'd0, 8'd0);
            if (frame_err) pop_check(2, 8'd0, 8'(err_code));
`ifdef CMD_ACK_EN
            if (transmit) begin
                if (ack_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_transmit actual=0x%0h required=none", tx_byte);
                end else begin
                    check("tx_byte", int'(tx_byte), int'(ack_q.pop_front()));
                end
            end
`else
            if (transmit || tx_byte != 8'd0) begin
                checks++;
                failures++;
                $display("FAIL transmit_tied actual=%0b/0x%0h required=0/0x0", transmit, tx_byte);
            end
`endif
        end
    end

    task automatic push_wr(input logic [7:0] a, input logic [7:0] d);
        ev_t e;
        e.kind = 0; e.a = a; e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic push_ok();
        ev_t e;
        e.kind = 1; e.a = 8'd0; e.d = 8'd0;
        exp_q.push_back(e);
`ifdef CMD_ACK_EN
        ack_q.push_back(8'h06);
`endif
    endtask

    task automatic push_err(input logic [7:0] code);
        ev_t e;
        e.kind = 2; e.a = 8'd0; e.d = code;
        exp_q.push_back(e);
`ifdef CMD_ACK_EN
        ack_q.push_back(8'h15);
`endif
    endtask

    task automatic send(input logic [7:0] b);
        @(posedge clk); #1;
        received = 1'b1;
        rx_byte  = b;
        @(posedge clk); #1;
        received = 1'b0;
    endtask

    task automatic pulse_line_err();
        @(posedge clk); #1;
        recv_error = 1'b1;
        @(posedge clk); #1;
        recv_error = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || ack_q.size() != 0) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_drained"}, exp_q.size() + ack_q.size(), 0);
        exp_q.delete();
        ack_q.delete();
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; received = 1'b0; recv_error = 1'b0; rx_byte = 8'd0;
        wr_ready = 1'b1; tx_free = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_wr_valid", wr_valid, 0);
        check("rst_err_code", err_code, 0);
        check("rst_overrun", overrun, 0);
        check("rst_frame_flags", {frame_ok, frame_err}, 0);
        rst = 1'b0;

        // Good frame: two writes on consecutive cycles, first valid right after CHK.
        push_wr(8'h10, 8'h01); push_wr(8'h11, 8'h02); push_ok();
        send(8'hA5); send(8'h02); send(8'h10); send(8'h01); send(8'h02); send(8'hED);
        check("first_write_latency", wr_valid, 1);
        @(posedge clk); #1;
        check("second_write_next_cycle", {wr_valid, wr_addr}, {1'b1, 8'h11});
        wait_drain("good");

        // Bad checksum.
        push_err(8'd2);
        send(8'hA5); send(8'h02); send(8'h10); send(8'h01); send(8'h02); send(8'hEE);
        wait_drain("chksum");
        check("err_code_held", err_code, 2);

        // Length zero and length above MAXLEN.
        push_err(8'd1);
        send(8'hA5); send(8'h00);
        wait_drain("len0");
        push_err(8'd1);
        send(8'hA5); send(8'h11);
        wait_drain("len17");

        push_wr(8'h10, 8'h01); push_wr(8'h11, 8'h02); push_ok();
        send(8'hA5); send(8'h02); send(8'h10); send(8'h01); send(8'h02); send(8'hED);
        wait_drain("good_after_badlen");

        // Inter-byte silence aborts, then a one-byte frame at address 0xFF.
        push_err(8'd4);
        send(8'hA5); send(8'h01); send(8'hFF);
        wait_drain("timeout");
        push_wr(8'hFF, 8'h07); push_ok();
        send(8'hA5); send(8'h01); send(8'hFF); send(8'h07); send(8'hFA);
        wait_drain("addr_ff");

        // Address wraps 0xFF -> 0x00 within a burst.
        push_wr(8'hFF, 8'h07); push_wr(8'h00, 8'h08); push_ok();
        send(8'hA5); send(8'h02); send(8'hFF); send(8'h07); send(8'h08); send(8'hF2);
        wait_drain("addr_wrap");

        // SYNC value inside the payload is plain data.
        push_wr(8'h40, 8'hA5); push_ok();
        send(8'hA5); send(8'h01); send(8'h40); send(8'hA5); send(8'h1B);
        wait_drain("sync_as_data");

        // Line error mid-frame.
        push_err(8'd3);
        send(8'hA5); send(8'h03);
        pulse_line_err();
        wait_drain("line_err");

        // Stalled DRAIN: byte arrives -> overrun, outputs held until ready.
        wr_ready = 1'b0;
        push_wr(8'h20, 8'hAA); push_wr(8'h21, 8'hBB); push_ok();
        send(8'hA5); send(8'h02); send(8'h20); send(8'hAA); send(8'hBB); send(8'h7B);
        check("overrun_before", overrun, 0);
        send(8'h99);
        repeat (4) @(posedge clk);
        #1;
        check("overrun_sticky", overrun, 1);
        check("stall_held", {wr_valid, wr_addr, wr_data}, {1'b1, 8'h20, 8'hAA});
        wr_ready = 1'b1;
        wait_drain("stall");

        // Reset mid-DRAIN drops the frame.
        wr_ready = 1'b0;
        send(8'hA5); send(8'h01); send(8'h30); send(8'h55); send(8'h7B);
        check("drain_before_rst", wr_valid, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_mid_drain_outputs", {wr_valid, frame_ok, frame_err, overrun, err_code},
              8'd0);
        wr_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        push_wr(8'hFF, 8'h07); push_ok();
        send(8'hA5); send(8'h01); send(8'hFF); send(8'h07); send(8'hFA);
        wait_drain("after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "global timeout");
    end
endmodule
